// File: rtl/centroid_calc.sv
// Frame centroid engine: accumulates matched pixel coordinates per frame and drives an
// external unsigned divider to publish the mean x/y position once per frame.
module centroid_calc #(
    parameter int unsigned DIV_WIDTH = 32,
    parameter int unsigned X_W       = 10,
    parameter int unsigned Y_W       = 9,
    parameter int unsigned MIN_COUNT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pixel_valid,
    input  logic                 pixel_match,
    input  logic [X_W-1:0]       x,
    input  logic [Y_W-1:0]       y,
    input  logic                 frame_end,
    output logic                 div_start,
    output logic [DIV_WIDTH-1:0] div_dividend,
    output logic [DIV_WIDTH-1:0] div_divider,
    output logic                 div_sign,
    input  logic [DIV_WIDTH-1:0] div_quotient,
    input  logic                 div_ready,
    output logic [X_W-1:0]       centroid_x,
    output logic [Y_W-1:0]       centroid_y,
    output logic                 found,
    output logic                 centroid_valid,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        StIdle, StStartX, StWaitX, StStartY, StWaitY, StPublish
    } state_e;

    state_e               r_state;
    logic [DIV_WIDTH-1:0] r_sum_x, r_sum_y, r_count;
    logic [DIV_WIDTH-1:0] r_hold_y;
    logic [DIV_WIDTH-1:0] r_dividend, r_divider;
    logic                 r_div_start;
    logic                 r_pend_found;
    logic [X_W-1:0]       r_x_tmp, r_centroid_x;
    logic [Y_W-1:0]       r_y_tmp, r_centroid_y;
    logic                 r_found, r_centroid_valid, r_overrun;

    logic                 w_match;
    logic [DIV_WIDTH-1:0] w_sum_x_nxt, w_sum_y_nxt, w_count_nxt;
    logic                 w_enough;
    logic                 w_unused;

    // The frame_end cycle's own match belongs to the ending frame.
    assign w_match     = pixel_valid & pixel_match;
    assign w_sum_x_nxt = r_sum_x + (w_match ? DIV_WIDTH'(x) : '0);
    assign w_sum_y_nxt = r_sum_y + (w_match ? DIV_WIDTH'(y) : '0);
    assign w_count_nxt = r_count + DIV_WIDTH'(w_match);
    assign w_enough    = w_count_nxt >= DIV_WIDTH'(MIN_COUNT);
    assign w_unused    = ^div_quotient;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= StIdle;
            r_sum_x          <= '0;
            r_sum_y          <= '0;
            r_count          <= '0;
            r_hold_y         <= '0;
            r_dividend       <= '0;
            r_divider        <= '0;
            r_div_start      <= 1'b0;
            r_pend_found     <= 1'b0;
            r_x_tmp          <= '0;
            r_y_tmp          <= '0;
            r_centroid_x     <= '0;
            r_centroid_y     <= '0;
            r_found          <= 1'b0;
            r_centroid_valid <= 1'b0;
            r_overrun        <= 1'b0;
        end else begin
            r_div_start      <= 1'b0;
            r_centroid_valid <= 1'b0;

            if (frame_end) begin
                r_sum_x <= '0;
                r_sum_y <= '0;
                r_count <= '0;
            end else begin
                r_sum_x <= w_sum_x_nxt;
                r_sum_y <= w_sum_y_nxt;
                r_count <= w_count_nxt;
            end

            if (frame_end && r_state != StIdle) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                StIdle: begin
                    if (frame_end) begin
                        // x sum and count are held directly in the divider operand registers.
                        r_hold_y     <= w_sum_y_nxt;
                        r_dividend   <= w_sum_x_nxt;
                        r_divider    <= w_count_nxt;
                        r_pend_found <= w_enough;
                        if (w_enough) begin
                            r_div_start <= 1'b1;
                            r_state     <= StStartX;
                        end else begin
                            r_state     <= StPublish;
                        end
                    end
                end
                StStartX: r_state <= StWaitX;
                StWaitX: begin
                    if (div_ready) begin
                        r_x_tmp     <= div_quotient[X_W-1:0];
                        r_dividend  <= r_hold_y;
                        r_div_start <= 1'b1;
                        r_state     <= StStartY;
                    end
                end
                StStartY: r_state <= StWaitY;
                StWaitY: begin
                    if (div_ready) begin
                        r_y_tmp <= div_quotient[Y_W-1:0];
                        r_state <= StPublish;
                    end
                end
                StPublish: begin
                    r_centroid_valid <= 1'b1;
                    r_found          <= r_pend_found;
                    if (r_pend_found) begin
                        r_centroid_x <= r_x_tmp;
                        r_centroid_y <= r_y_tmp;
                    end
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign div_start      = r_div_start;
    assign div_dividend   = r_dividend;
    assign div_divider    = r_divider;
    assign div_sign       = 1'b0;
    assign centroid_x     = r_centroid_x;
    assign centroid_y     = r_centroid_y;
    assign found          = r_found;
    assign centroid_valid = r_centroid_valid;
    assign overrun        = r_overrun;

endmodule
